// File: rtl/seq101_frame_tx.sv
// seq101_frame_tx: serialises a word as "101" sync, MSB-first data, optional even parity, then a zero gap
module seq101_frame_tx #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 1,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              x_out,
   output logic              busy,
   output logic              done
);
   localparam int M1   = DATA_W > 3 ? DATA_W : 3;
   localparam int MAXC = M1 > GAP_CYCLES ? M1 : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] DLAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GLAST = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;

   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [DATA_W-1:0] sr, sr_d;
   logic              par, par_d, x_d, done_d;

   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;

   // state, counters, shift register and registered line/done outputs; async clear abandons any frame
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
         par   <= 1'b0;
         x_out <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         sr    <= sr_d;
         par   <= par_d;
         x_out <= x_d;
         done  <= done_d;
      end
   end

   // next state and the bit driven onto the line at the coming edge; the accept edge emits the first sync 1
   always_comb begin
      state_d = state;
      sr_d    = sr;
      par_d   = par;
      x_d     = 1'b0;
      done_d  = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            state_d = SYNC;
            sr_d    = in_data;
            par_d   = ^in_data;
            x_d     = 1'b1;
         end
         SYNC: begin
            x_d     = cnt == ONE;
            state_d = cnt == ONE ? DATA : SYNC;
         end
         DATA: begin
            x_d  = sr[DATA_W-1];
            sr_d = sr << 1;
            if (cnt == DLAST) state_d = (PARITY_EN != 0) ? PAR : GAP;
         end
         PAR: begin
            x_d     = par;
            state_d = GAP;
         end
         GAP: if (cnt == GLAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = (state_d != state || state == IDLE) ? '0 : cnt + ONE;
   end
endmodule

// File: tb/tb_seq101_frame_tx.sv
// tb_seq101_frame_tx: vector table, hand sequences and randomized frame-level model plus line receiver
module tb_seq101_frame_tx;
   logic       clk = 1'b0, aresetn = 1'b0;
   logic       va = 1'b0, vb = 1'b0;
   logic [7:0] da = '0;
   logic [3:0] db = '0;
   logic       xa, ra, ba, dna, xb, rb, bb, dnb;
   int         cmp = 0, mism = 0;
   int         pa = -1, pb = -1;
   logic [31:0] wa = '0, wb = '0;
   bit         rx_en = 1'b0;
   logic [7:0] acc_q[$];
   int         rxn = 0, dcnt = 0, nacc = 0, rcnt = -1;
   logic [2:0] hist = '0;
   logic [31:0] rw = '0;

   typedef struct {logic v; logic [7:0] d; logic x; logic r; logic dn;} vec_t;
   vec_t tv[15];

   seq101_frame_tx #(.DATA_W(8), .PARITY_EN(1), .GAP_CYCLES(2)) ua (
      .clk(clk), .aresetn(aresetn), .in_data(da), .in_valid(va),
      .in_ready(ra), .x_out(xa), .busy(ba), .done(dna));

   seq101_frame_tx #(.DATA_W(4), .PARITY_EN(0), .GAP_CYCLES(1)) ub (
      .clk(clk), .aresetn(aresetn), .in_data(db), .in_valid(vb),
      .in_ready(rb), .x_out(xb), .busy(bb), .done(dnb));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // bit k of a frame as {last_bit_of_frame, line_bit}, straight from the framing rules
   function automatic logic [1:0] fbit(int dw, int pe, int g, logic [31:0] d, int k);
      logic b;
      if (k < 3) b = (k != 1);
      else if (k < 3 + dw) b = d[dw - 1 - (k - 3)];
      else if (pe != 0 && k == 3 + dw) b = ^d;
      else b = 1'b0;
      return {k == 2 + dw + pe + g, b};
   endfunction

   task automatic rx_bit(input logic b);
      logic [7:0] e;
      if (rcnt < 0) begin
         hist = {hist[1:0], b};
         if (hist == 3'b101) begin
            rcnt = 0;
            rw = '0;
         end
      end else if (rcnt < 8) begin
         rw = {rw[30:0], b};
         rcnt++;
      end else begin
         if (rx_en) begin
            chk("rx_parity", {31'b0, b}, {31'b0, ^rw});
            if (acc_q.size() == 0) begin
               e = 8'hxx;
               chk("rx_extra_word", 32'd1, 32'd0);
            end else e = acc_q.pop_front();
            chk("rx_word", rw, {24'b0, e});
            rxn++;
         end
         rcnt = -1;
         hist = '0;
      end
   endtask

   task automatic step();
      logic [1:0] ea, eb;
      ea = '0;
      eb = '0;
      if (pa < 0 && va) begin
         pa = 0;
         wa = {24'b0, da};
         if (rx_en) begin
            acc_q.push_back(da);
            nacc++;
         end
      end
      if (pa >= 0) begin
         ea = fbit(8, 1, 2, wa, pa);
         pa++;
         if (ea[1]) pa = -1;
      end
      if (pb < 0 && vb) begin
         pb = 0;
         wb = {28'b0, db};
      end
      if (pb >= 0) begin
         eb = fbit(4, 0, 1, wb, pb);
         pb++;
         if (eb[1]) pb = -1;
      end
      @(posedge clk);
      #1;
      chk("a_x", xa, ea[0]);
      chk("a_done", dna, ea[1]);
      chk("a_ready", ra, pa < 0);
      chk("a_busy", ba, pa >= 0);
      chk("b_x", xb, eb[0]);
      chk("b_done", dnb, eb[1]);
      chk("b_ready", rb, pb < 0);
      chk("b_busy", bb, pb >= 0);
      if (rx_en && dna) dcnt++;
      rx_bit(xa);
   endtask

   task automatic rstep();
      vb = 1'($urandom_range(0, 1));
      db = 4'($urandom);
      step();
   endtask

   initial begin
      logic [14:0] xs;
      logic [14:0] got15;
      logic [8:0]  got9;
      xs = 15'b101101001010000;
      for (int i = 0; i < 15; i++) begin
         tv[i].v  = (i == 0);
         tv[i].d  = (i == 0) ? 8'hA5 : 8'h5A;
         tv[i].x  = xs[14 - i];
         tv[i].r  = (i >= 13);
         tv[i].dn = (i == 13);
      end

      for (int i = 0; i < 5; i++) begin
         va = 1'($urandom_range(0, 1));
         da = 8'($urandom);
         vb = 1'($urandom_range(0, 1));
         db = 4'($urandom);
         @(posedge clk);
         #1;
         chk("rst_a_x", xa, 0);
         chk("rst_a_ready", ra, 1);
         chk("rst_a_busy", ba, 0);
         chk("rst_a_done", dna, 0);
         chk("rst_b_x", xb, 0);
         chk("rst_b_ready", rb, 1);
      end
      va = 1'b0;
      vb = 1'b0;
      aresetn = 1'b1;
      repeat (20) step();

      for (int i = 0; i < 15; i++) begin
         va = tv[i].v;
         da = tv[i].d;
         step();
         chk("tbl_x", xa, tv[i].x);
         chk("tbl_ready", ra, tv[i].r);
         chk("tbl_done", dna, tv[i].dn);
      end
      va = 1'b0;
      repeat (3) step();

      va = 1'b1;
      da = 8'h07;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i == 0) da = 8'h3C;
         got15[14 - i] = xa;
      end
      va = 1'b0;
      chk("b2b_line", {17'b0, got15}, {17'b0, 15'b101000001111001});
      repeat (16) step();

      va = 1'b1;
      da = 8'hFF;
      step();
      va = 1'b0;
      repeat (5) step();
      aresetn = 1'b0;
      #1;
      chk("midrst_x", xa, 0);
      chk("midrst_ready", ra, 1);
      chk("midrst_busy", ba, 0);
      chk("midrst_done", dna, 0);
      pa = -1;
      pb = -1;
      @(posedge clk);
      #1;
      chk("midrst_hold_x", xa, 0);
      aresetn = 1'b1;
      repeat (4) step();
      va = 1'b1;
      da = 8'h01;
      step();
      va = 1'b0;
      repeat (15) step();

      vb = 1'b1;
      db = 4'b1101;
      for (int i = 0; i < 9; i++) begin
         step();
         got9[8 - i] = xb;
         if (i == 7) chk("var_ready_E7", rb, 1);
      end
      vb = 1'b0;
      chk("var_line", {23'b0, got9}, {23'b0, 9'b101110101});
      repeat (10) step();

      rx_en = 1'b1;
      acc_q.delete();
      rcnt = -1;
      hist = '0;
      for (int w = 0; w < 200; w++) begin
         logic [7:0] wd;
         bit acc;
         wd = 8'($urandom);
         va = 1'b0;
         repeat ($urandom_range(0, 3)) rstep();
         acc = 1'b0;
         for (int t = 0; t < 40 && !acc; t++) begin
            if (pa < 0) begin
               va = 1'b1;
               da = wd;
               acc = 1'b1;
            end else begin
               va = 1'($urandom_range(0, 1));
               da = 8'($urandom);
            end
            rstep();
         end
         if (!acc) chk("accept_bound", 0, 1);
         va = 1'b0;
      end
      va = 1'b0;
      repeat (20) rstep();
      chk("rx_count", rxn, nacc);
      chk("done_count", dcnt, nacc);
      chk("rx_missing", acc_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end
endmodule
